// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the data bus, with a per-transaction
// watchdog that completes hung commands with an error response.
module dbus_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_cmd_addr_i,
    input  logic        m0_cmd_we_i,
    input  logic        m0_cmd_valid_i,
    output logic        m0_cmd_ack_o,
    output logic [31:0] m0_read_data_o,
    input  logic [31:0] m0_write_data_i,
    input  logic [3:0]  m0_write_en_i,

    input  logic [31:0] m1_cmd_addr_i,
    input  logic        m1_cmd_we_i,
    input  logic        m1_cmd_valid_i,
    output logic        m1_cmd_ack_o,
    output logic [31:0] m1_read_data_o,
    input  logic [31:0] m1_write_data_i,
    input  logic [3:0]  m1_write_en_i,

    output logic [31:0] s_cmd_addr_o,
    output logic        s_cmd_we_o,
    output logic        s_cmd_valid_o,
    output logic [31:0] s_write_data_o,
    output logic [3:0]  s_write_en_o,
    input  logic        s_cmd_ack_i,
    input  logic [31:0] s_read_data_i,

    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic        err_master_o,
    input  logic        err_clr_i
);

    localparam int unsigned      CNT_W     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             rr_last_reg, rr_last_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             err_reg, err_next;
    logic [31:0]      err_addr_reg, err_addr_next;
    logic             err_master_reg, err_master_next;

    logic [1:0]  m_valid;
    logic [1:0]  m_we;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wen   [2];
    logic [1:0]  m_ack;
    logic [31:0] m_rdata [2];

    logic grant_any;
    logic grant_idx;
    logic wd_fire;
    logic slave_done;

    assign m_valid    = {m1_cmd_valid_i, m0_cmd_valid_i};
    assign m_we       = {m1_cmd_we_i, m0_cmd_we_i};
    assign m_addr[0]  = m0_cmd_addr_i;
    assign m_addr[1]  = m1_cmd_addr_i;
    assign m_wdata[0] = m0_write_data_i;
    assign m_wdata[1] = m1_write_data_i;
    assign m_wen[0]   = m0_write_en_i;
    assign m_wen[1]   = m1_write_en_i;

    // Grant decode: IDLE arbitrates, BUSYn only ever forwards master n.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_any = |m_valid;
                grant_idx = (&m_valid) ? ~rr_last_reg : m_valid[1];
            end
            BUSY0: begin
                grant_any = m_valid[0];
                grant_idx = 1'b0;
            end
            BUSY1: begin
                grant_any = m_valid[1];
                grant_idx = 1'b1;
            end
            default: ;
        endcase
    end

    assign wd_fire    = (TIMEOUT != 0) && (state_reg != IDLE) && grant_any
                        && (wait_cnt_reg == CNT_LIMIT);
    assign slave_done = grant_any && s_cmd_ack_i && !wd_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            rr_last_reg    <= 1'b1;
            wait_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            err_addr_reg   <= '0;
            err_master_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_last_reg    <= rr_last_next;
            wait_cnt_reg   <= wait_cnt_next;
            err_reg        <= err_next;
            err_addr_reg   <= err_addr_next;
            err_master_reg <= err_master_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_last_next    = rr_last_reg;
        wait_cnt_next   = wait_cnt_reg;
        err_addr_next   = err_addr_reg;
        err_master_next = err_master_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    if (slave_done) begin
                        rr_last_next = grant_idx;
                    end else begin
                        state_next    = grant_idx ? BUSY1 : BUSY0;
                        wait_cnt_next = CNT_ONE;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (!grant_any) begin
                    // Master withdrew without an ack: abandon, keep rr_last.
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wd_fire || slave_done) begin
                    state_next    = IDLE;
                    rr_last_next  = grant_idx;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Set wins over clear when both happen in the same cycle.
        if (wd_fire) begin
            err_next        = 1'b1;
            err_addr_next   = m_addr[grant_idx];
            err_master_next = grant_idx;
        end else if (err_clr_i) begin
            err_next = 1'b0;
        end
    end

    always_comb begin
        s_cmd_addr_o   = '0;
        s_cmd_we_o     = 1'b0;
        s_cmd_valid_o  = 1'b0;
        s_write_data_o = '0;
        s_write_en_o   = '0;
        if (grant_any && !rst_i) begin
            s_cmd_addr_o   = m_addr[grant_idx];
            s_cmd_we_o     = m_we[grant_idx];
            s_cmd_valid_o  = !wd_fire;
            s_write_data_o = m_wdata[grant_idx];
            s_write_en_o   = m_wen[grant_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic granted;
            assign granted     = !rst_i && grant_any && (grant_idx == 1'(gi));
            assign m_ack[gi]   = granted && (slave_done || wd_fire);
            assign m_rdata[gi] = !granted ? 32'd0 : (wd_fire ? ERR_DATA : s_read_data_i);
        end
    endgenerate

    assign m0_cmd_ack_o   = m_ack[0];
    assign m1_cmd_ack_o   = m_ack[1];
    assign m0_read_data_o = m_rdata[0];
    assign m1_read_data_o = m_rdata[1];

    assign err_o        = err_reg;
    assign err_addr_o   = err_addr_reg;
    assign err_master_o = err_master_reg;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: behavioural model of owner/age/round-robin
// predicts every output each cycle; directed prelude covers reset and timeout.
module tb_dbus_arbiter;

    localparam int          TO  = 5;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_cmd_addr_i, m1_cmd_addr_i;
    logic        m0_cmd_we_i, m1_cmd_we_i;
    logic        m0_cmd_valid_i, m1_cmd_valid_i;
    logic        m0_cmd_ack_o, m1_cmd_ack_o;
    logic [31:0] m0_read_data_o, m1_read_data_o;
    logic [31:0] m0_write_data_i, m1_write_data_i;
    logic [3:0]  m0_write_en_i, m1_write_en_i;
    logic [31:0] s_cmd_addr_o;
    logic        s_cmd_we_o, s_cmd_valid_o;
    logic [31:0] s_write_data_o;
    logic [3:0]  s_write_en_o;
    logic        s_cmd_ack_i;
    logic [31:0] s_read_data_i;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_master_o;
    logic        err_clr_i;

    dbus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cmd_addr_i(m0_cmd_addr_i), .m0_cmd_we_i(m0_cmd_we_i),
        .m0_cmd_valid_i(m0_cmd_valid_i), .m0_cmd_ack_o(m0_cmd_ack_o),
        .m0_read_data_o(m0_read_data_o), .m0_write_data_i(m0_write_data_i),
        .m0_write_en_i(m0_write_en_i),
        .m1_cmd_addr_i(m1_cmd_addr_i), .m1_cmd_we_i(m1_cmd_we_i),
        .m1_cmd_valid_i(m1_cmd_valid_i), .m1_cmd_ack_o(m1_cmd_ack_o),
        .m1_read_data_o(m1_read_data_o), .m1_write_data_i(m1_write_data_i),
        .m1_write_en_i(m1_write_en_i),
        .s_cmd_addr_o(s_cmd_addr_o), .s_cmd_we_o(s_cmd_we_o),
        .s_cmd_valid_o(s_cmd_valid_o), .s_write_data_o(s_write_data_o),
        .s_write_en_o(s_write_en_o), .s_cmd_ack_i(s_cmd_ack_i),
        .s_read_data_i(s_read_data_i),
        .err_o(err_o), .err_addr_o(err_addr_o), .err_master_o(err_master_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model state
    int          owner;       // -1 when no command is in flight
    int          age;         // cycles since grant of the in-flight command
    int          rr_last;
    bit          m_err;
    logic [31:0] m_err_addr;
    bit          m_err_master;
    int          slave_lat;   // remaining wait before the slave acks, -1 = unassigned

    // Master stimulus
    bit          act [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic        we  [2];
    logic [3:0]  be  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner        = -1;
        age          = 0;
        rr_last      = 1;
        m_err        = 1'b0;
        m_err_addr   = '0;
        m_err_master = 1'b0;
        slave_lat    = -1;
    endtask

    // One bus cycle: entered just after a rising edge, leaves just after the next.
    task automatic cycle(input bit do_rst, input bit clr, input int lat_override);
        int          cand;
        bit          fire, exp_valid, s_ack, done;
        bit          exp_ack [2];
        logic [31:0] exp_rd  [2];
        logic [31:0] rd_now;

        rst_i           = do_rst;
        err_clr_i       = clr;
        m0_cmd_valid_i  = act[0];
        m0_cmd_addr_i   = a[0];
        m0_cmd_we_i     = we[0];
        m0_write_data_i = wd[0];
        m0_write_en_i   = be[0];
        m1_cmd_valid_i  = act[1];
        m1_cmd_addr_i   = a[1];
        m1_cmd_we_i     = we[1];
        m1_write_data_i = wd[1];
        m1_write_en_i   = be[1];
        rd_now          = $urandom;
        s_read_data_i   = rd_now;

        cand = -1;
        fire = 1'b0;
        if (do_rst) begin
            model_reset();
        end else if (owner < 0) begin
            if (act[0] && act[1]) cand = 1 - rr_last;
            else if (act[0])      cand = 0;
            else if (act[1])      cand = 1;
        end else if (act[owner]) begin
            cand = owner;
            fire = (age == TO);
        end

        exp_valid = (cand >= 0) && !fire;
        if (exp_valid && slave_lat < 0)
            slave_lat = (lat_override >= 0) ? lat_override :
                        (($urandom_range(0, 99) < 15) ? 1000 : int'($urandom_range(0, 3)));
        s_ack       = exp_valid && (slave_lat == 0);
        s_cmd_ack_i = s_ack;
        done        = (cand >= 0) && (fire || s_ack);

        for (int i = 0; i < 2; i++) begin
            exp_ack[i] = done && (cand == i);
            exp_rd[i]  = (cand == i) ? (fire ? ERR : rd_now) : 32'd0;
        end

        #1;
        chk("s_valid", s_cmd_valid_o, exp_valid);
        chk("m0_ack", m0_cmd_ack_o, exp_ack[0]);
        chk("m1_ack", m1_cmd_ack_o, exp_ack[1]);
        chk("err", err_o, m_err);
        chk("err_addr", err_addr_o, m_err_addr);
        chk("err_master", err_master_o, m_err_master);
        if (!do_rst) begin
            chk("m0_rdata", m0_read_data_o, exp_rd[0]);
            chk("m1_rdata", m1_read_data_o, exp_rd[1]);
            if (exp_valid) begin
                chk("s_addr", s_cmd_addr_o, a[cand]);
                chk("s_we", s_cmd_we_o, we[cand]);
                chk("s_wdata", s_write_data_o, wd[cand]);
                chk("s_wen", s_write_en_o, be[cand]);
            end else if (cand < 0) begin
                chk("s_idle_addr", s_cmd_addr_o, 32'd0);
                chk("s_idle_wdata", s_write_data_o, 32'd0);
                chk("s_idle_wen", s_write_en_o, 4'd0);
            end
        end

        if (done) begin
            txn++;
            $display("txn %0d m%0d %s addr=%h rdata=%h%s", txn, cand, we[cand] ? "wr" : "rd",
                     a[cand], exp_rd[cand], fire ? " timeout" : "");
        end

        if (!do_rst) begin
            if (fire) begin
                m_err        = 1'b1;
                m_err_addr   = a[cand];
                m_err_master = cand[0];
            end else if (clr) begin
                m_err = 1'b0;
            end
            if (cand < 0) begin
                owner = -1;
                age   = 0;
            end else if (done) begin
                rr_last = cand;
                owner   = -1;
                age     = 0;
                act[cand] = 1'b0;
            end else begin
                age   = (owner < 0) ? 1 : age + 1;
                owner = cand;
            end
            if (exp_valid && !s_ack) slave_lat--;
            else slave_lat = -1;
        end

        @(posedge clk_i);
        #1;
    endtask

    task automatic new_req(input int i);
        act[i] = 1'b1;
        a[i]   = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
        we[i]  = $urandom_range(0, 1);
        wd[i]  = $urandom;
        be[i]  = 4'($urandom_range(0, 15));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; a[i] = '0; wd[i] = '0; we[i] = 1'b0; be[i] = '0;
        end
        rst_i = 1'b1; err_clr_i = 1'b0; s_cmd_ack_i = 1'b0; s_read_data_i = '0;
        m0_cmd_valid_i = 1'b0; m1_cmd_valid_i = 1'b0;
        m0_cmd_addr_i = '0; m1_cmd_addr_i = '0; m0_cmd_we_i = 1'b0; m1_cmd_we_i = 1'b0;
        m0_write_data_i = '0; m1_write_data_i = '0; m0_write_en_i = '0; m1_write_en_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;

        // Reset holds the bus quiet even with both masters requesting.
        act[0] = 1'b1; act[1] = 1'b1;
        cycle(1'b1, 1'b0, -1);
        act[0] = 1'b0; act[1] = 1'b0;

        // Single uncontended read, slave acks in the grant cycle.
        act[0] = 1'b1; a[0] = 32'h100; we[0] = 1'b0; wd[0] = '0; be[0] = '0;
        cycle(1'b0, 1'b0, 0);

        // Contended, slave waits 2 cycles each: m0 first, then m1.
        new_req(0); new_req(1);
        repeat (6) cycle(1'b0, 1'b0, 2);

        // Continuous contention with zero-wait slave: strict alternation.
        for (int n = 0; n < 6; n++) begin
            if (!act[0]) new_req(0);
            if (!act[1]) new_req(1);
            cycle(1'b0, 1'b0, 0);
        end

        // Hung write from m1; clear pulsed in the timeout cycle, then alone.
        act[1] = 1'b1; a[1] = 32'h2000; we[1] = 1'b1; wd[1] = 32'hCAFE; be[1] = 4'hF;
        repeat (TO) cycle(1'b0, 1'b0, 1000);
        cycle(1'b0, 1'b1, 1000);
        cycle(1'b0, 1'b0, -1);
        cycle(1'b0, 1'b1, -1);
        cycle(1'b0, 1'b0, -1);

        // Reset in the middle of a slow m0 transaction.
        new_req(0);
        cycle(1'b0, 1'b0, 2);
        cycle(1'b1, 1'b0, 2);
        act[0] = 1'b0;
        cycle(1'b0, 1'b0, -1);

        for (int n = 0; n < 3000; n++) begin
            bit do_rst;
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(0, 1) == 1) new_req(i);
                else if (act[i] && $urandom_range(0, 149) == 0) act[i] = 1'b0;
            end
            do_rst = ($urandom_range(0, 399) == 0);
            cycle(do_rst, $urandom_range(0, 19) == 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
